instr_fetch: RTL and testbench

- Fetch stage directly upstream of ID: owns the PC, issues instruction-memory reads over a valid/ready request and valid-only response handshake, and presents Instr/PC/PC+4 to ID.
- Honours ID's registered branch/jump redirect (Alt_PC / Request_Alt_PC) and freeze request (WANT_FREEZE).
- Emits NOP bubbles (32'h0) when no instruction is available.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_hold_buffer.sv | 39 +++
 rtl/instr_fetch.sv | 186 ++++++++++++++++++
 tb/tb_instr_fetch.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding,
// bubble instruction and PC arithmetic helpers.
package fetch_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t STATE_REQ  = 2'd0;
    localparam fetch_state_t STATE_WAIT = 2'd1;
    localparam fetch_state_t STATE_HOLD = 2'd2;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INCR   = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// Single-entry {instr, pc} holding register used to park a response that
// arrives while ID is frozen.
module fetch_hold_buffer
    import fetch_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        load,
    input  logic        drop,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    logic        valid_reg;
    logic [31:0] instr_reg;
    logic [31:0] pc_reg;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            valid_reg <= 1'b0;
            instr_reg <= NOP_INSTR;
            pc_reg    <= 32'h0;
        end else if (load) begin
            valid_reg <= 1'b1;
            instr_reg <= instr_in;
            pc_reg    <= pc_in;
        end else if (drop) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid = valid_reg;
    assign instr = instr_reg;
    assign pc    = pc_reg;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues one outstanding instruction-memory read at
// a time, and feeds Instr/PC/PC+4 to ID with redirect, freeze and bubbles.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        FREEZE,
    input  logic [31:0] Alt_PC_IN,
    input  logic        Request_Alt_PC_IN,
    output logic        IMem_Req_Valid,
    output logic [31:0] IMem_Req_Addr,
    input  logic        IMem_Req_Ready,
    input  logic        IMem_Resp_Valid,
    input  logic [31:0] IMem_Resp_Data,
    output logic [31:0] Instr_OUT,
    output logic [31:0] Instr_PC_OUT,
    output logic [31:0] Instr_PC_Plus4_OUT,
    output logic        Instr_Valid_OUT
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  pend_pc_reg, pend_pc_next;
    logic         kill_reg, kill_next;
    // A redirect seen while a request is stalled leaves that request on the
    // bus at its old address; stale_* remembers it so PC can already move on.
    logic         stale_reg, stale_next;
    logic [31:0]  stale_addr_reg, stale_addr_next;

    logic [31:0]  instr_reg, instr_next;
    logic [31:0]  ipc_reg, ipc_next;
    logic [31:0]  ipc4_reg, ipc4_next;
    logic         ivalid_reg, ivalid_next;

    logic         hold_load, hold_drop, hold_valid;
    logic [31:0]  hold_instr, hold_pc;

    logic         deliver;
    logic [31:0]  deliver_instr, deliver_pc;
    logic [31:0]  alt_pc;
    logic         redirect;

    assign redirect = Request_Alt_PC_IN;
    assign alt_pc   = word_align(Alt_PC_IN);

    assign IMem_Req_Valid = RESET && (state_reg == STATE_REQ);
    assign IMem_Req_Addr  = stale_reg ? stale_addr_reg : pc_reg;

    fetch_hold_buffer u_hold (
        .CLK      (CLK),
        .RESET    (RESET),
        .load     (hold_load),
        .drop     (hold_drop),
        .instr_in (IMem_Resp_Data),
        .pc_in    (pend_pc_reg),
        .valid    (hold_valid),
        .instr    (hold_instr),
        .pc       (hold_pc)
    );

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        pend_pc_next    = pend_pc_reg;
        kill_next       = kill_reg;
        stale_next      = stale_reg;
        stale_addr_next = stale_addr_reg;
        hold_load       = 1'b0;
        hold_drop       = 1'b0;
        deliver         = 1'b0;
        deliver_instr   = NOP_INSTR;
        deliver_pc      = 32'h0;

        case (state_reg)
            STATE_REQ: begin
                if (IMem_Req_Ready) begin
                    state_next = STATE_WAIT;
                    if (redirect) begin
                        pc_next    = alt_pc;
                        kill_next  = 1'b1;
                        stale_next = 1'b0;
                    end else if (stale_reg) begin
                        kill_next  = 1'b1;
                        stale_next = 1'b0;
                    end else begin
                        pend_pc_next = pc_reg;
                        pc_next      = pc_reg + PC_INCR;
                    end
                end else if (redirect) begin
                    pc_next = alt_pc;
                    if (!stale_reg) begin
                        stale_next      = 1'b1;
                        stale_addr_next = pc_reg;
                    end
                end
            end
            STATE_WAIT: begin
                if (redirect) begin
                    pc_next = alt_pc;
                end
                if (IMem_Resp_Valid) begin
                    state_next = STATE_REQ;
                    kill_next  = 1'b0;
                    if (!kill_reg && !redirect) begin
                        if (FREEZE) begin
                            hold_load  = 1'b1;
                            state_next = STATE_HOLD;
                        end else begin
                            deliver       = 1'b1;
                            deliver_instr = IMem_Resp_Data;
                            deliver_pc    = pend_pc_reg;
                        end
                    end
                end else if (redirect) begin
                    kill_next = 1'b1;
                end
            end
            STATE_HOLD: begin
                if (redirect) begin
                    hold_drop  = 1'b1;
                    pc_next    = alt_pc;
                    state_next = STATE_REQ;
                end else if (!FREEZE) begin
                    hold_drop     = 1'b1;
                    state_next    = STATE_REQ;
                    deliver       = hold_valid;
                    deliver_instr = hold_instr;
                    deliver_pc    = hold_pc;
                end
            end
            default: begin
                state_next = STATE_REQ;
            end
        endcase
    end

    // ID-facing outputs: frozen values are held, otherwise a fetched
    // instruction or a NOP bubble.
    always_comb begin
        instr_next  = instr_reg;
        ipc_next    = ipc_reg;
        ipc4_next   = ipc4_reg;
        ivalid_next = ivalid_reg;
        if (!FREEZE) begin
            instr_next  = deliver ? deliver_instr : NOP_INSTR;
            ipc_next    = deliver ? deliver_pc : 32'h0;
            ipc4_next   = deliver ? (deliver_pc + PC_INCR) : 32'h0;
            ivalid_next = deliver;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_reg      <= STATE_REQ;
            pc_reg         <= word_align(RESET_PC);
            pend_pc_reg    <= 32'h0;
            kill_reg       <= 1'b0;
            stale_reg      <= 1'b0;
            stale_addr_reg <= 32'h0;
            instr_reg      <= NOP_INSTR;
            ipc_reg        <= 32'h0;
            ipc4_reg       <= 32'h0;
            ivalid_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            pend_pc_reg    <= pend_pc_next;
            kill_reg       <= kill_next;
            stale_reg      <= stale_next;
            stale_addr_reg <= stale_addr_next;
            instr_reg      <= instr_next;
            ipc_reg        <= ipc_next;
            ipc4_reg       <= ipc4_next;
            ivalid_reg     <= ivalid_next;
        end
    end

    assign Instr_OUT          = instr_reg;
    assign Instr_PC_OUT       = ipc_reg;
    assign Instr_PC_Plus4_OUT = ipc4_reg;
    assign Instr_Valid_OUT    = ivalid_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch: reset, fetch, redirect,
// freeze, stalled-request redirect, PC wrap and mid-transaction reset.
module tb_instr_fetch;

    logic        CLK;
    logic        RESET;
    logic        FREEZE;
    logic [31:0] Alt_PC_IN;
    logic        Request_Alt_PC_IN;
    logic        IMem_Req_Valid;
    logic [31:0] IMem_Req_Addr;
    logic        IMem_Req_Ready;
    logic        IMem_Resp_Valid;
    logic [31:0] IMem_Resp_Data;
    logic [31:0] Instr_OUT;
    logic [31:0] Instr_PC_OUT;
    logic [31:0] Instr_PC_Plus4_OUT;
    logic        Instr_Valid_OUT;

    int pass_cnt = 0;
    int total_cnt = 0;

    instr_fetch #(.RESET_PC(32'hBFC00000)) dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .FREEZE             (FREEZE),
        .Alt_PC_IN          (Alt_PC_IN),
        .Request_Alt_PC_IN  (Request_Alt_PC_IN),
        .IMem_Req_Valid     (IMem_Req_Valid),
        .IMem_Req_Addr      (IMem_Req_Addr),
        .IMem_Req_Ready     (IMem_Req_Ready),
        .IMem_Resp_Valid    (IMem_Resp_Valid),
        .IMem_Resp_Data     (IMem_Resp_Data),
        .Instr_OUT          (Instr_OUT),
        .Instr_PC_OUT       (Instr_PC_OUT),
        .Instr_PC_Plus4_OUT (Instr_PC_Plus4_OUT),
        .Instr_Valid_OUT    (Instr_Valid_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b0; FREEZE = 1'b0; Alt_PC_IN = 32'h0; Request_Alt_PC_IN = 1'b0;
        IMem_Req_Ready = 1'b0; IMem_Resp_Valid = 1'b0; IMem_Resp_Data = 32'h0;
        tick(); tick();
        total_cnt++; if (IMem_Req_Valid !== 1'b0) $display("FAIL reset_req_valid got %b exp 0", IMem_Req_Valid); else pass_cnt++;
        total_cnt++; if (Instr_OUT !== 32'h0) $display("FAIL reset_instr got %h exp 00000000", Instr_OUT); else pass_cnt++;
        total_cnt++; if (Instr_PC_OUT !== 32'h0) $display("FAIL reset_pc got %h exp 00000000", Instr_PC_OUT); else pass_cnt++;
        total_cnt++; if (Instr_PC_Plus4_OUT !== 32'h0) $display("FAIL reset_pc4 got %h exp 00000000", Instr_PC_Plus4_OUT); else pass_cnt++;
        total_cnt++; if (Instr_Valid_OUT !== 1'b0) $display("FAIL reset_valid got %b exp 0", Instr_Valid_OUT); else pass_cnt++;
        RESET = 1'b1;
        #1;
        total_cnt++; if (IMem_Req_Valid !== 1'b1 || IMem_Req_Addr !== 32'hBFC00000) $display("FAIL first_req got v=%b a=%h exp v=1 a=bfc00000", IMem_Req_Valid, IMem_Req_Addr); else pass_cnt++;
        $display("reset: first request v=%b addr=%h", IMem_Req_Valid, IMem_Req_Addr);
    endtask

    task automatic test_basic_fetch();
        IMem_Req_Ready = 1'b1;
        tick();
        IMem_Req_Ready = 1'b0;
        total_cnt++; if (IMem_Req_Valid !== 1'b0) $display("FAIL wait_req_valid got %b exp 0", IMem_Req_Valid); else pass_cnt++;
        IMem_Resp_Valid = 1'b1; IMem_Resp_Data = 32'h11111111;
        tick();
        IMem_Resp_Valid = 1'b0;
        total_cnt++; if (Instr_OUT !== 32'h11111111 || Instr_PC_OUT !== 32'hBFC00000 || Instr_PC_Plus4_OUT !== 32'hBFC00004 || Instr_Valid_OUT !== 1'b1)
            $display("FAIL fetch1 got %h/%h/%h/%b exp 11111111/bfc00000/bfc00004/1", Instr_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT, Instr_Valid_OUT); else pass_cnt++;
        total_cnt++; if (IMem_Req_Valid !== 1'b1 || IMem_Req_Addr !== 32'hBFC00004) $display("FAIL req2 got v=%b a=%h exp v=1 a=bfc00004", IMem_Req_Valid, IMem_Req_Addr); else pass_cnt++;
        IMem_Req_Ready = 1'b1;
        tick();
        IMem_Req_Ready = 1'b0;
        total_cnt++; if (Instr_OUT !== 32'h0 || Instr_Valid_OUT !== 1'b0) $display("FAIL bubble got %h/%b exp 00000000/0", Instr_OUT, Instr_Valid_OUT); else pass_cnt++;
        IMem_Resp_Valid = 1'b1; IMem_Resp_Data = 32'h22222222;
        tick();
        IMem_Resp_Valid = 1'b0;
        total_cnt++; if (Instr_OUT !== 32'h22222222 || Instr_PC_OUT !== 32'hBFC00004 || Instr_PC_Plus4_OUT !== 32'hBFC00008)
            $display("FAIL fetch2 got %h/%h/%h exp 22222222/bfc00004/bfc00008", Instr_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT); else pass_cnt++;
        $display("basic: instr=%h pc=%h", Instr_OUT, Instr_PC_OUT);
    endtask

    task automatic test_redirect_wait();
        total_cnt++; if (IMem_Req_Addr !== 32'hBFC00008) $display("FAIL req3 got %h exp bfc00008", IMem_Req_Addr); else pass_cnt++;
        FREEZE = 1'b1; IMem_Req_Ready = 1'b1;
        tick();
        IMem_Req_Ready = 1'b0;
        Request_Alt_PC_IN = 1'b1; Alt_PC_IN = 32'h00400003;
        tick();
        Request_Alt_PC_IN = 1'b0;
        total_cnt++; if (Instr_OUT !== 32'h22222222 || Instr_PC_OUT !== 32'hBFC00004) $display("FAIL delay_slot got %h/%h exp 22222222/bfc00004", Instr_OUT, Instr_PC_OUT); else pass_cnt++;
        FREEZE = 1'b0; IMem_Resp_Valid = 1'b1; IMem_Resp_Data = 32'hDEADBEEF;
        tick();
        IMem_Resp_Valid = 1'b0;
        total_cnt++; if (Instr_OUT !== 32'h0 || Instr_Valid_OUT !== 1'b0) $display("FAIL squash_wait got %h/%b exp 00000000/0", Instr_OUT, Instr_Valid_OUT); else pass_cnt++;
        total_cnt++; if (IMem_Req_Valid !== 1'b1 || IMem_Req_Addr !== 32'h00400000) $display("FAIL redirect_addr got v=%b a=%h exp v=1 a=00400000", IMem_Req_Valid, IMem_Req_Addr); else pass_cnt++;
        IMem_Req_Ready = 1'b1;
        tick();
        IMem_Req_Ready = 1'b0; IMem_Resp_Valid = 1'b1; IMem_Resp_Data = 32'h33333333;
        tick();
        IMem_Resp_Valid = 1'b0;
        total_cnt++; if (Instr_OUT !== 32'h33333333 || Instr_PC_OUT !== 32'h00400000) $display("FAIL target_fetch got %h/%h exp 33333333/00400000", Instr_OUT, Instr_PC_OUT); else pass_cnt++;
        $display("redirect_wait: instr=%h pc=%h", Instr_OUT, Instr_PC_OUT);
    endtask

    task automatic test_freeze();
        FREEZE = 1'b1; IMem_Req_Ready = 1'b1;
        tick();
        IMem_Req_Ready = 1'b0; IMem_Resp_Valid = 1'b1; IMem_Resp_Data = 32'h44444444;
        tick();
        IMem_Resp_Valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++; if (Instr_OUT !== 32'h33333333 || Instr_PC_OUT !== 32'h00400000 || IMem_Req_Valid !== 1'b0)
                $display("FAIL freeze_hold%0d got %h/%h reqv=%b exp 33333333/00400000 reqv=0", i, Instr_OUT, Instr_PC_OUT, IMem_Req_Valid); else pass_cnt++;
        end
        FREEZE = 1'b0;
        tick();
        total_cnt++; if (Instr_OUT !== 32'h44444444 || Instr_PC_OUT !== 32'h00400004 || Instr_Valid_OUT !== 1'b1)
            $display("FAIL unfreeze got %h/%h/%b exp 44444444/00400004/1", Instr_OUT, Instr_PC_OUT, Instr_Valid_OUT); else pass_cnt++;
        total_cnt++; if (IMem_Req_Addr !== 32'h00400008) $display("FAIL after_hold_addr got %h exp 00400008", IMem_Req_Addr); else pass_cnt++;
        $display("freeze: released instr=%h pc=%h", Instr_OUT, Instr_PC_OUT);
    endtask

    task automatic test_stall_redirect();
        tick();
        Request_Alt_PC_IN = 1'b1; Alt_PC_IN = 32'h00001000;
        tick();
        Request_Alt_PC_IN = 1'b0;
        total_cnt++; if (IMem_Req_Valid !== 1'b1 || IMem_Req_Addr !== 32'h00400008) $display("FAIL stall_addr got v=%b a=%h exp v=1 a=00400008", IMem_Req_Valid, IMem_Req_Addr); else pass_cnt++;
        tick();
        total_cnt++; if (IMem_Req_Addr !== 32'h00400008) $display("FAIL stall_addr2 got %h exp 00400008", IMem_Req_Addr); else pass_cnt++;
        IMem_Req_Ready = 1'b1;
        tick();
        IMem_Req_Ready = 1'b0; IMem_Resp_Valid = 1'b1; IMem_Resp_Data = 32'h55555555;
        tick();
        IMem_Resp_Valid = 1'b0;
        total_cnt++; if (Instr_OUT !== 32'h0 || Instr_Valid_OUT !== 1'b0) $display("FAIL stale_squash got %h/%b exp 00000000/0", Instr_OUT, Instr_Valid_OUT); else pass_cnt++;
        total_cnt++; if (IMem_Req_Addr !== 32'h00001000) $display("FAIL stall_target got %h exp 00001000", IMem_Req_Addr); else pass_cnt++;
        $display("stall_redirect: next addr=%h", IMem_Req_Addr);
    endtask

    task automatic test_wrap();
        IMem_Req_Ready = 1'b1; Request_Alt_PC_IN = 1'b1; Alt_PC_IN = 32'hFFFFFFFC;
        tick();
        IMem_Req_Ready = 1'b0; Request_Alt_PC_IN = 1'b0;
        IMem_Resp_Valid = 1'b1; IMem_Resp_Data = 32'h66666666;
        tick();
        IMem_Resp_Valid = 1'b0;
        total_cnt++; if (Instr_Valid_OUT !== 1'b0 || IMem_Req_Addr !== 32'hFFFFFFFC) $display("FAIL accept_redirect got v=%b a=%h exp v=0 a=fffffffc", Instr_Valid_OUT, IMem_Req_Addr); else pass_cnt++;
        IMem_Req_Ready = 1'b1;
        tick();
        IMem_Req_Ready = 1'b0; IMem_Resp_Valid = 1'b1; IMem_Resp_Data = 32'h77777777;
        tick();
        IMem_Resp_Valid = 1'b0;
        total_cnt++; if (Instr_OUT !== 32'h77777777 || Instr_PC_OUT !== 32'hFFFFFFFC || Instr_PC_Plus4_OUT !== 32'h0)
            $display("FAIL wrap_out got %h/%h/%h exp 77777777/fffffffc/00000000", Instr_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT); else pass_cnt++;
        total_cnt++; if (IMem_Req_Addr !== 32'h0) $display("FAIL wrap_addr got %h exp 00000000", IMem_Req_Addr); else pass_cnt++;
        $display("wrap: pc=%h pc4=%h next=%h", Instr_PC_OUT, Instr_PC_Plus4_OUT, IMem_Req_Addr);
    endtask

    task automatic test_back_to_back();
        IMem_Req_Ready = 1'b1;
        tick();
        IMem_Req_Ready = 1'b0;
        IMem_Resp_Valid = 1'b1; IMem_Resp_Data = 32'h88888888;
        Request_Alt_PC_IN = 1'b1; Alt_PC_IN = 32'h00002000;
        tick();
        IMem_Resp_Valid = 1'b0; Request_Alt_PC_IN = 1'b0;
        total_cnt++; if (Instr_Valid_OUT !== 1'b0 || IMem_Req_Addr !== 32'h00002000) $display("FAIL same_cycle_squash got v=%b a=%h exp v=0 a=00002000", Instr_Valid_OUT, IMem_Req_Addr); else pass_cnt++;
        IMem_Req_Ready = 1'b1;
        tick();
        IMem_Req_Ready = 1'b0; IMem_Resp_Valid = 1'b1; IMem_Resp_Data = 32'h99999999;
        tick();
        IMem_Resp_Valid = 1'b0;
        total_cnt++; if (Instr_OUT !== 32'h99999999 || Instr_PC_OUT !== 32'h00002000) $display("FAIL no_stale_kill got %h/%h exp 99999999/00002000", Instr_OUT, Instr_PC_OUT); else pass_cnt++;
        $display("back_to_back: instr=%h pc=%h", Instr_OUT, Instr_PC_OUT);
    endtask

    task automatic test_reset_midtxn();
        IMem_Req_Ready = 1'b1;
        tick();
        IMem_Req_Ready = 1'b0; RESET = 1'b0;
        tick();
        total_cnt++; if (IMem_Req_Valid !== 1'b0 || Instr_OUT !== 32'h0 || Instr_PC_OUT !== 32'h0 || Instr_Valid_OUT !== 1'b0)
            $display("FAIL midreset got reqv=%b %h/%h/%b exp 0 00000000/00000000/0", IMem_Req_Valid, Instr_OUT, Instr_PC_OUT, Instr_Valid_OUT); else pass_cnt++;
        RESET = 1'b1; IMem_Resp_Valid = 1'b1; IMem_Resp_Data = 32'hAAAAAAAA;
        tick();
        IMem_Resp_Valid = 1'b0;
        total_cnt++; if (Instr_OUT !== 32'h0 || Instr_Valid_OUT !== 1'b0) $display("FAIL post_reset_resp got %h/%b exp 00000000/0", Instr_OUT, Instr_Valid_OUT); else pass_cnt++;
        total_cnt++; if (IMem_Req_Valid !== 1'b1 || IMem_Req_Addr !== 32'hBFC00000) $display("FAIL post_reset_req got v=%b a=%h exp v=1 a=bfc00000", IMem_Req_Valid, IMem_Req_Addr); else pass_cnt++;
        $display("reset_midtxn: next addr=%h", IMem_Req_Addr);
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_redirect_wait();
        test_freeze();
        test_stall_redirect();
        test_wrap();
        test_back_to_back();
        test_reset_midtxn();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
